// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_BURST_LEN = 4;

  // Beat counter width; one spare bit so BURST_LEN itself is representable.
  function automatic int unsigned cnt_w(input int unsigned burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot after
// last_grant sits at bit 0, priority-encode, then rotate the index back.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        start;
  int unsigned        off;
  logic               found;

  always_comb begin
    start = (32'(last_grant) + 32'd1) % NUM_REQ;
    rot   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rot[IDX_W'(i)] = req[IDX_W'((start + i) % NUM_REQ)];
    end
    off   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rot[IDX_W'(i)] && !found) begin
        off   = i;
        found = 1'b1;
      end
    end
    winner  = IDX_W'((start + off) % NUM_REQ);
    any_req = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Ready/wr_en/data are combinational from the registered grant and the full flag.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic                     i_fifo_full,
  output logic                     o_fifo_wr_en,
  output logic [WIDTH-1:0]         o_fifo_data,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy
);

  localparam int unsigned     IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned     CNT_W     = cnt_w(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               g_valid_c;
  logic               xfer_c;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               fifo_wr_en_c;
  logic [WIDTH-1:0]   fifo_data_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (i_req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Next-state, burst accounting and write-port muxing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    req_ready_c  = '0;
    fifo_wr_en_c = 1'b0;
    fifo_data_c  = '0;
    g_valid_c    = |(i_req_valid & grant_q);
    xfer_c       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d    = ARB_BURST;
          grant_d    = NUM_REQ'(1) << winner;
          gidx_d     = winner;
          beat_cnt_d = '0;
        end
      end
      ARB_BURST: begin
        req_ready_c  = grant_q & {NUM_REQ{!i_fifo_full}};
        xfer_c       = g_valid_c && !i_fifo_full;
        fifo_wr_en_c = xfer_c;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          if (grant_q[k]) fifo_data_c = i_req_data[k*WIDTH +: WIDTH];
        end
        // Release on a dropped valid or on the final beat of the burst.
        if (!g_valid_c || (xfer_c && beat_cnt_q == LAST_BEAT)) begin
          state_d      = ARB_IDLE;
          grant_d      = '0;
          beat_cnt_d   = '0;
          last_grant_d = gidx_q;
        end else if (xfer_c) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      beat_cnt_q   <= '0;
      last_grant_q <= LAST_IDX;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_req_ready  = req_ready_c;
  assign o_fifo_wr_en = fifo_wr_en_c;
  assign o_fifo_data  = fifo_data_c;
  assign o_grant      = grant_q;
  assign o_busy       = (state_q == ARB_BURST);

  a_no_write_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_fifo_wr_en |-> !i_fifo_full);
  a_grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_grant));
  a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_ready));
  a_beat_cnt_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    beat_cnt_q < CNT_W'(BURST_LEN));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a cycle-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned N          = DEF_NUM_REQ;
  localparam int unsigned W          = DEF_WIDTH;
  localparam int unsigned B          = DEF_BURST_LEN;
  localparam int unsigned STARVE_MAX = (N - 1) * (B + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data;
  logic [N-1:0]   grant;
  logic           busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST_LEN(B)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_fifo_full  (fifo_full),
    .o_fifo_wr_en (fifo_wr_en),
    .o_fifo_data  (fifo_data),
    .o_grant      (grant),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Producers: each holds the head of its queue on the bus until it transfers.
  logic [W-1:0] pq [N][$];
  logic [W-1:0] gen [N][$];
  logic [N-1:0] fired;

  always @(negedge clk) fired = req_valid & req_ready;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (fired[k] && pq[k].size() != 0) void'(pq[k].pop_front());
      req_valid[k]      = (pq[k].size() != 0);
      req_data[k*W +: W] = (pq[k].size() != 0) ? pq[k][0] : '0;
    end
  end

  // Reference model: owner index (-1 idle), beats taken, last owner.
  int m_owner;
  int m_beats;
  int m_last;

  always @(posedge clk or negedge rst_n) begin
    int c;
    if (!rst_n) begin
      m_owner = -1;
      m_beats = 0;
      m_last  = N - 1;
    end else if (m_owner < 0) begin
      for (int s = 1; s <= N; s++) begin
        c = (m_last + s) % N;
        if (req_valid[c] && m_owner < 0) begin
          m_owner = c;
          m_beats = 0;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (!fifo_full) begin
      m_beats++;
      if (m_beats == B) begin
        m_last  = m_owner;
        m_owner = -1;
        m_beats = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    logic         ew, eb;
    logic [W-1:0] ed;
    eg = '0; er = '0; ew = 1'b0; ed = '0; eb = 1'b0;
    if (rst_n && m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      er[m_owner] = !fifo_full;
      ew          = req_valid[m_owner] && !fifo_full;
      ed          = req_data[m_owner*W +: W];
      eb          = 1'b1;
    end
    check("model{grant,ready,wr,data,busy}", {grant, req_ready, fifo_wr_en, fifo_data, busy},
          {eg, er, ew, ed, eb});
  end

  // Monitor: burst log, write log, starvation and producer hold rule.
  int           burst_owner[$];
  int           burst_beats[$];
  int           gap_log[$];
  logic [W-1:0] wdata_log[$];
  logic [W-1:0] prod_wlog [N][$];
  int           idle_run;
  int           starve [N];
  logic [N-1:0] prev_g;
  logic [N-1:0] prev_v, prev_r;
  logic [N*W-1:0] prev_d;
  logic         prev_rst;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_g   = '0;
      idle_run = 0;
      prev_rst = 1'b0;
      for (int k = 0; k < N; k++) starve[k] = 0;
    end else begin
      if (grant != '0 && prev_g == '0) begin
        burst_owner.push_back(idx_of(grant));
        burst_beats.push_back(0);
        gap_log.push_back(idle_run);
      end
      if (grant == '0) idle_run++;
      else idle_run = 0;
      if (fifo_wr_en) begin
        wdata_log.push_back(fifo_data);
        if (burst_beats.size() != 0) burst_beats[burst_beats.size()-1]++;
        prod_wlog[idx_of(grant)].push_back(fifo_data);
      end
      if (fifo_full) check("no_wr_while_full", 32'(fifo_wr_en), 32'd0);
      for (int k = 0; k < N; k++) begin
        if (grant[k] && !prev_g[k]) begin
          check("starvation_bound", 32'(starve[k] <= STARVE_MAX), 32'd1);
          starve[k] = 0;
        end else if (!req_valid[k]) starve[k] = 0;
        else if (!grant[k] && busy && !fifo_full) starve[k]++;
        if (prev_rst && prev_v[k] && !prev_r[k])
          assert (req_valid[k] && req_data[k*W +: W] == prev_d[k*W +: W])
            else $error("producer %0d dropped or changed data before ready", k);
      end
      prev_g   = grant;
      prev_v   = req_valid;
      prev_r   = req_ready;
      prev_d   = req_data;
      prev_rst = 1'b1;
    end
  end

  task automatic clear_logs();
    burst_owner.delete();
    burst_beats.delete();
    gap_log.delete();
    wdata_log.delete();
    for (int k = 0; k < N; k++) begin
      prod_wlog[k].delete();
      gen[k].delete();
    end
  endtask

  task automatic enter_reset();
    @(posedge clk); #2;
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    for (int k = 0; k < N; k++) pq[k].delete();
    repeat (2) @(posedge clk);
    #2;
    clear_logs();
  endtask

  task automatic leave_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_writes(input int n, input string name);
    for (int i = 0; i < 40 && wdata_log.size() < n; i++) begin
      @(negedge clk); #1;
    end
    check(name, 32'(wdata_log.size() >= n), 32'd1);
  endtask

  task automatic check_words(input string name, input logic [W-1:0] exp [$]);
    check({name, "_count"}, 32'(wdata_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wdata_log.size(); i++)
      check(name, 32'(wdata_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [W-1:0] exp_w [$];
    logic [W-1:0] w;
    int           pending;

    rst_n     = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // All producers busy: owners 0,1,2,3,0, four beats each, one idle cycle between.
    clear_logs();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 8; j++) pq[k].push_back(W'(k * 4 + j));
    leave_reset();
    repeat (28) @(posedge clk);
    #2;
    check("t1_nbursts", 32'(burst_owner.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < burst_owner.size(); i++) begin
      check("t1_owner", 32'(burst_owner[i]), 32'(i % 4));
      check("t1_beats", 32'(burst_beats[i]), 32'd4);
      if (i > 0) check("t1_gap", 32'(gap_log[i]), 32'd1);
    end

    // Lone producer 2 with six words: burst of 4, bubble, regrant for 2 more.
    enter_reset();
    exp_w = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD};
    foreach (exp_w[i]) pq[2].push_back(exp_w[i]);
    leave_reset();
    repeat (20) @(posedge clk);
    #2;
    check("t2_nbursts", 32'(burst_owner.size()), 32'd2);
    if (burst_owner.size() == 2) begin
      check("t2_owner0", 32'(burst_owner[0]), 32'd2);
      check("t2_owner1", 32'(burst_owner[1]), 32'd2);
      check("t2_beats0", 32'(burst_beats[0]), 32'd4);
      check("t2_beats1", 32'(burst_beats[1]), 32'd2);
      check("t2_gap", 32'(gap_log[1]), 32'd1);
    end
    check_words("t2_data", exp_w);

    // Producer 1 stalled by a full FIFO for five cycles after its second beat.
    enter_reset();
    exp_w = '{4'h1, 4'h2, 4'h3, 4'h4};
    foreach (exp_w[i]) pq[1].push_back(exp_w[i]);
    leave_reset();
    wait_writes(2, "t3_reach_beat2");
    @(posedge clk); #2;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("t3_stall_wr_en", 32'(fifo_wr_en), 32'd0);
      check("t3_stall_ready", 32'(req_ready), 32'd0);
      check("t3_stall_grant", 32'(grant), 32'b0010);
      check("t3_stall_beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
    end
    @(posedge clk); #2;
    fifo_full = 1'b0;
    @(negedge clk); #1;
    check("t3_resume_wr_en", 32'(fifo_wr_en), 32'd1);
    repeat (8) @(posedge clk);
    #2;
    check("t3_nbursts", 32'(burst_owner.size()), 32'd1);
    if (burst_beats.size() != 0) check("t3_beats", 32'(burst_beats[0]), 32'd4);
    check_words("t3_data", exp_w);

    // Producer 0 releases after one beat; rotation moves on to producer 2.
    enter_reset();
    pq[0].push_back(4'h6);
    pq[2].push_back(4'h8);
    pq[2].push_back(4'h9);
    leave_reset();
    repeat (15) @(posedge clk);
    #2;
    check("t4_nbursts", 32'(burst_owner.size()), 32'd2);
    if (burst_owner.size() == 2) begin
      check("t4_owner0", 32'(burst_owner[0]), 32'd0);
      check("t4_beats0", 32'(burst_beats[0]), 32'd1);
      check("t4_owner1", 32'(burst_owner[1]), 32'd2);
    end
    exp_w = '{4'h6, 4'h8, 4'h9};
    check_words("t4_data", exp_w);

    // Reset in the middle of producer 3's burst clears outputs immediately.
    enter_reset();
    for (int j = 0; j < 8; j++) pq[3].push_back(W'(j + 1));
    leave_reset();
    wait_writes(2, "t5_reach_beat2");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_grant", 32'(grant), 32'd0);
    check("t5_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < N; k++) pq[k].delete();
    repeat (2) @(posedge clk);
    #2;
    clear_logs();
    for (int k = 0; k < N; k++) begin
      pq[k].push_back(W'(k));
      pq[k].push_back(W'(k + 8));
    end
    leave_reset();
    repeat (8) @(posedge clk);
    #2;
    check("t5_first_owner", 32'(burst_owner.size() != 0 ? burst_owner[0] : 99), 32'd0);

    // Random valid/full traffic with a per-producer order scoreboard.
    enter_reset();
    leave_reset();
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #2;
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) begin
        if (pq[k].size() < 3 && $urandom_range(0, 2) == 0) begin
          w = W'($urandom);
          pq[k].push_back(w);
          gen[k].push_back(w);
        end
      end
    end
    @(posedge clk); #2;
    fifo_full = 1'b0;
    pending = 1;
    for (int i = 0; i < 2000 && pending != 0; i++) begin
      @(posedge clk); #2;
      pending = 0;
      for (int k = 0; k < N; k++) pending += pq[k].size();
    end
    check("rnd_drained", 32'(pending), 32'd0);
    repeat (6) @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      check("rnd_count", 32'(prod_wlog[k].size()), 32'(gen[k].size()));
      for (int i = 0; i < gen[k].size() && i < prod_wlog[k].size(); i++)
        check("rnd_order", 32'(prod_wlog[k][i]), 32'(gen[k][i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one syncFIFO_v2 write port among NUM_REQ producers.
- Grants one producer at a time and holds the grant for a burst of up to BURST_LEN beats.
- Drives the FIFO wr_en and i_data, and never writes while the FIFO reports full.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers; must be >= 2.
- WIDTH, 4, data width; must equal the FIFO WIDTH.
- BURST_LEN, 4, maximum beats per grant; must be >= 1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-producer data valid
- i_req_data  in  NUM_REQ*WIDTH  flattened producer data; producer k occupies bits [k*WIDTH +: WIDTH]
- o_req_ready  out  NUM_REQ  per-producer accept; a beat transfers when valid[k] && ready[k]
- i_fifo_full  in  1  FIFO o_full
- o_fifo_wr_en  out  1  to FIFO wr_en
- o_fifo_data  out  WIDTH  to FIFO i_data
- o_grant  out  NUM_REQ  registered one-hot grant; 0 when idle
- o_busy  out  1  high in BURST state

Behaviour:
- Reset (async, active-low, effective immediately):
  - state=IDLE, o_grant=0, beat_cnt=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: o_req_ready=0, o_fifo_wr_en=0, o_fifo_data=0, o_busy=0.
- IDLE:
  - No ready, no write.
  - If any i_req_valid, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Next edge: o_grant=onehot(winner), beat_cnt=0, state=BURST.
  - If no valid, stay in IDLE.
- Latency: valid rising in IDLE gives the earliest transfer on the 2nd edge (1 arbitration cycle + 1 transfer cycle).
- BURST, with g = granted index:
  - o_req_ready[g] = !i_fifo_full; every other ready bit is 0.
  - o_fifo_wr_en = i_req_valid[g] && !i_fifo_full (combinational from registered grant).
  - o_fifo_data = data slice g while in BURST, else 0.
  - Transfer increments beat_cnt.
- Exit to IDLE, taken on the same edge:
  - (a) a transfer with beat_cnt==BURST_LEN-1, or
  - (b) i_req_valid[g]==0 (voluntary release; no transfer that cycle).
  - On exit: last_grant<=g, o_grant<=0, beat_cnt<=0.
- FIFO full in BURST: grant is held, no write, beat_cnt unchanged. No timeout; a full FIFO stalls the granted producer indefinitely.
- Simultaneous full deassert and valid: the write occurs that cycle.
- Exit is always followed by at least one IDLE cycle, so back-to-back bursts have a 1-cycle bubble. The same producer may win again only if no other producer is valid.
- beat_cnt width: $clog2(BURST_LEN)+1; it never wraps because exit occurs at BURST_LEN-1.
- BURST_LEN=1: every transfer ends the burst.
- Producer rule (checked by bench assertion): once valid, data and valid hold until ready.
- Internal assertions:
  - o_fifo_wr_en implies !i_fifo_full.
  - o_grant is $onehot0.
  - At most one o_req_ready bit is set.
  - beat_cnt < BURST_LEN.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t
  - default constants for NUM_REQ, WIDTH, BURST_LEN
  - function cnt_w(BURST_LEN)
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector, last_grant.
  - Outputs: winner index and any_req.
  - Implemented as a rotate, priority-encode, rotate back.
- The top module holds the FSM, counters and muxing.

Test Plan:
- Reset then req_valid=4'b1111, FIFO never full -> grants in order 0,1,2,3,0; each grant yields exactly 4 wr_en beats; 1 idle cycle between bursts.
- Only req 2 valid, with 6 data words A0..A5 -> burst of 4 (A0-A3), one IDLE cycle, req 2 regranted, A4,A5 written, then release on valid drop; FIFO data order A0..A5.
- Grant to req 1; i_fifo_full=1 for 5 cycles after beat 2 -> wr_en=0 and ready[1]=0 for those 5 cycles, grant held, beat_cnt=2; beats 3-4 complete after full drops.
- req_valid 4'b0101, req 0 drops valid after 1 beat -> burst ends with 1 beat, next grant goes to req 2 (not 0).
- Assert i_rst_n=0 mid-burst at beat 2 of req 3 -> same cycle o_grant=0, o_fifo_wr_en=0, o_busy=0; after release with all valid, req 0 granted first.
- Random valid/full traffic for 10k cycles, scoreboard per producer -> FIFO read order per producer matches write order; no write while full; no producer starved beyond (NUM_REQ-1)*(BURST_LEN+1) non-full cycles.
